// File: rtl/led_status_tx.sv
// led_status_tx: on a single-cycle report request, snapshots the six 7-seg digit
// codes and the display mode, then sends a 9-byte ASCII status line over a UART
// (8N1, LSB first): mode char, in5..in0 chars, CR, LF.
// Optional build macro LED_STATUS_TX_PARITY_EN inserts an even-parity bit
// between data bit 7 and the stop bit (8E1 framing).
//
// state    | meaning
// ---------+------------------------------------------------
// S_IDLE   | line idle high, waiting for report
// S_START  | start bit (0) of the current byte
// S_DATA   | data bits 0..7 of the current byte, LSB first
// S_PARITY | even parity of the current byte (macro builds only)
// S_STOP   | stop bit (1); last byte's stop ends the message
module led_status_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] in0,
    input  logic [4:0] in1,
    input  logic [4:0] in2,
    input  logic [4:0] in3,
    input  logic [4:0] in4,
    input  logic [4:0] in5,
    input  logic [1:0] mode,
    input  logic       report,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef LED_STATUS_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  LAST_BYTE = 4'd8;

    logic [2:0]       state_q, state_d;
    logic [15:0]      baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [3:0]       byte_q, byte_d;
    logic [1:0]       snap_mode_q, snap_mode_d;
    logic [5:0][4:0]  snap_dig_q, snap_dig_d;   // index i holds the in<i> code
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       cur_char;
    logic             baud_tick;

    function automatic logic [7:0] digit_char(input logic [4:0] code);
        return (code < 5'd10) ? (8'h30 + {3'b000, code}) : 8'h2D;
    endfunction

    // ASCII character for the byte currently being framed, from the snapshot
    always_comb begin
        cur_char = 8'h0A;
        case (byte_q)
            4'd0: begin
                case (snap_mode_q)
                    2'd0:    cur_char = 8'h47;
                    2'd1:    cur_char = 8'h50;
                    2'd2:    cur_char = 8'h44;
                    default: cur_char = 8'h3F;
                endcase
            end
            4'd1:    cur_char = digit_char(snap_dig_q[5]);
            4'd2:    cur_char = digit_char(snap_dig_q[4]);
            4'd3:    cur_char = digit_char(snap_dig_q[3]);
            4'd4:    cur_char = digit_char(snap_dig_q[2]);
            4'd5:    cur_char = digit_char(snap_dig_q[1]);
            4'd6:    cur_char = digit_char(snap_dig_q[0]);
            4'd7:    cur_char = 8'h0D;
            default: cur_char = 8'h0A;
        endcase
    end

    assign baud_tick = (baud_q == BAUD_LAST);

    // Frame sequencer: tx is registered so each new bit appears on the edge that ends the previous one
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        snap_mode_d = snap_mode_q;
        snap_dig_d  = snap_dig_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = baud_tick ? 16'd0 : baud_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                baud_d = 16'd0;
                tx_d   = 1'b1;
                if (report) begin
                    snap_mode_d = mode;
                    snap_dig_d  = {in5, in4, in3, in2, in1, in0};
                    byte_d      = 4'd0;
                    bit_d       = 3'd0;
                    state_d     = S_START;
                    tx_d        = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    tx_d    = cur_char[0];
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (bit_q == 3'd7) begin
`ifdef LED_STATUS_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = ^cur_char;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_char[bit_q + 3'd1];
                    end
                end
            end
`ifdef LED_STATUS_TX_PARITY_EN
            S_PARITY: begin
                if (baud_tick) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_tick) begin
                    if (byte_q == LAST_BYTE) begin
                        state_d = S_IDLE;
                        byte_d  = 4'd0;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        byte_d  = byte_q + 4'd1;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset wins over any simultaneous report
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            baud_q      <= 16'd0;
            bit_q       <= 3'd0;
            byte_q      <= 4'd0;
            snap_mode_q <= 2'd0;
            snap_dig_q  <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            snap_mode_q <= snap_mode_d;
            snap_dig_q  <= snap_dig_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
